scv_keypad: RTL and testbench
=============================

// Module: scv_keypad
// PURPOSE
//  Front-panel/controller input stage feeding the uPD7800 port inputs.
//  Host key/joystick bits are synchronised and debounced. The resulting key matrix
//  is scanned by CPU port A (row select, active low) and returned on port B.
//  The pause switch is returned on port C bit 0.
//  Replaces the constant PB_I=8'hFF / PC_I=8'h01 ties in scv.
// PARAMETERS
//  DB_DIV  28636  CLK cycles per debounce sample tick (~1 kHz at 28.636 MHz)
//  DB_CNT  4      consecutive differing ticks needed to accept a new key state (>=1)
//  AF_DIV  33     autofire half-period, in sample ticks (used only with macro)
// PORTS
//  CLK        in   1   system clock (2 x video XTAL)
//  RESET      in   1   async reset, active high
//  KEYS_I     in   64  host key state, 1=pressed; bit r*8+c = matrix row r, column c
//  PAUSE_I    in   1   host pause button, 1=pressed
//  AF_MASK_I  in   64  autofire enable per key (port exists only with macro)
//  PA_I       in   8   CPU PA_O; row r selected when PA_I[r]==0
//  PB_O       out  8   to CPU PB_I; column c low when any selected row has c pressed
//  PC0_O      out  1   to CPU PC_I[0]; 1=pause off, 0=pause pressed
//  KEYS_DB_O  out  64  debounced key state (status/debug), 1=pressed
// BEHAVIOUR
//  Reset (async): PB_O=8'hFF, PC0_O=1, KEYS_DB_O=0, all sync/debounce/tick/AF state cleared,
//   af_phase=1. Outputs take reset values immediately on RESET rise, including mid-operation.
//  Sync: KEYS_I and PAUSE_I each pass through a 2-FF synchroniser.
//  Tick: counter 0..DB_DIV-1; tick asserted for 1 CLK when count==DB_DIV-1, then wraps to 0.
//  Debounce: 65 channels (64 keys + pause); per channel a stable bit and a cnt.
//   On tick: if sync==stable then cnt<=0; else if cnt==DB_CNT-1 then stable<=sync, cnt<=0;
//   else cnt<=cnt+1. Any agreeing tick restarts the count, so a bounce shorter than
//   DB_CNT ticks is rejected. The count is sized $clog2(DB_CNT) bits, min 1.
//  Effective key: eff[i]=stable[i] (see CONFIGURATION).
//  Matrix read: registered each CLK, 1-CLK latency from PA_I/eff change:
//   PB_O[c] <= ~|( ~PA_I[r] & eff[r*8+c] ) for r=0..7.
//   PA_I=8'hFF gives PB_O=8'hFF. Several rows low combine as wired-AND (OR of the
//   pressed keys). No ghosting is modelled.
//  PC0_O <= ~stable_pause, registered. KEYS_DB_O = stable[63:0].
//  Debounce runs continuously, independent of PA_I activity.
// CONFIGURATION
//  Macro SCV_KEYPAD_AUTOFIRE_EN:
//   Defined: AF_MASK_I present. af_phase toggles every AF_DIV ticks; its counter runs freely
//    from reset. eff[i]=stable[i] & (~AF_MASK_I[i] | af_phase). A masked held key reads
//    pressed/released in alternating AF_DIV-tick windows, and pressed immediately after reset.
//    AF_MASK_I is used unsynchronised and must be quasi-static.
//   Undefined: no AF_MASK_I port, no af counter; eff=stable; AF_DIV ignored.
// TESTING (bench uses DB_DIV=4, DB_CNT=3, AF_DIV=2)
//  1 Reset: RESET=1 with KEYS_I=all ones -> PB_O=FF, PC0_O=1, KEYS_DB_O=0; hold 20 CLK, unchanged.
//  2 Press/release: KEYS_I[3*8+5]=1 held, PA_I=8'hF7 -> KEYS_DB_O[29]=1 on 3rd tick after
//    sync; PB_O=8'hDF 1 CLK later. PA_I=8'hFE -> PB_O=FF next CLK. Release -> PB_O=FF
//    after 3 ticks (PA_I=F7).
//  3 Bounce: pulse KEYS_I[0] high for 2 ticks, low 1 tick, high 2 ticks -> KEYS_DB_O[0]
//    never set.
//  4 Multi-row: keys (0,1) and (7,6) held, PA_I=8'h7E -> PB_O=8'hBD; PA_I=8'h7F -> 8'hBF.
//  5 Pause/reset mid-op: PAUSE_I=1 -> PC0_O=0 after 3 ticks. Assert RESET -> PC0_O=1 at once.
//    Release RESET with PAUSE_I held -> PC0_O=0 again after sync + 3 ticks.
//  6 Autofire (macro on): AF_MASK_I[8]=1, key (1,0) held, PA_I=8'hFD -> once debounced,
//    PB_O[0] alternates 0/1 every 2 ticks (8 CLK); with AF_MASK_I=0 it stays 0.

Source files
------------

// File: rtl/scv_keypad.sv
`default_nettype none
// ============================================================================
// Module      : scv_keypad
// Description : Keypad/controller input stage for the uPD7800 ports. It
//               synchronises and debounces the host keys, scans the key matrix
//               with PA (row select, active low), and returns columns on PB and
//               pause on PC0. Optional autofire: SCV_KEYPAD_AUTOFIRE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module scv_keypad #(
    parameter int DB_DIV = 28636,
    parameter int DB_CNT = 4,
    parameter int AF_DIV = 33
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [63:0] KEYS_I,
    input  logic        PAUSE_I,
`ifdef SCV_KEYPAD_AUTOFIRE_EN
    input  logic [63:0] AF_MASK_I,
`endif
    input  logic [7:0]  PA_I,
    output logic [7:0]  PB_O,
    output logic        PC0_O,
    output logic [63:0] KEYS_DB_O
);

    localparam int c_DIV_W = (DB_DIV > 1) ? $clog2(DB_DIV) : 1;
    localparam int c_CNT_W = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(DB_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DB_CNT - 1);

    logic [64:0]        r_sync1;
    logic [64:0]        r_sync2;
    logic [c_DIV_W-1:0] r_div;
    logic               w_tick;
    logic [64:0]        w_stable;
    logic [63:0]        w_eff;
    logic [7:0]         w_pb;

    // Channel 64 is the pause switch; 63..0 are the matrix keys.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {PAUSE_I, KEYS_I};
            r_sync2 <= r_sync1;
        end
    end

    assign w_tick = (r_div == c_DIV_LAST);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Any agreeing tick restarts the count, so only DB_CNT consecutive
    // differing ticks move the stable value.
    for (genvar i = 0; i < 65; i++) begin : g_db
        logic [c_CNT_W-1:0] r_cnt;
        logic               r_stable;

        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                r_cnt    <= '0;
                r_stable <= 1'b0;
            end else if (w_tick) begin
                if (r_sync2[i] == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    r_stable <= r_sync2[i];
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_stable[i] = r_stable;
    end

`ifdef SCV_KEYPAD_AUTOFIRE_EN
    localparam int c_AF_W = (AF_DIV > 1) ? $clog2(AF_DIV) : 1;
    localparam logic [c_AF_W-1:0] c_AF_LAST = c_AF_W'(AF_DIV - 1);

    logic [c_AF_W-1:0] r_af_cnt;
    logic              r_af_phase;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_af_cnt   <= '0;
            r_af_phase <= 1'b1;
        end else if (w_tick) begin
            if (r_af_cnt == c_AF_LAST) begin
                r_af_cnt   <= '0;
                r_af_phase <= ~r_af_phase;
            end else begin
                r_af_cnt <= r_af_cnt + 1'b1;
            end
        end
    end

    assign w_eff = w_stable[63:0] & (~AF_MASK_I | {64{r_af_phase}});
`else
    // AF_DIV has no effect without autofire; this empty block only names it.
    if (AF_DIV < 1) begin : g_af_div_unused
    end

    assign w_eff = w_stable[63:0];
`endif

    always_comb begin
        w_pb = 8'hFF;
        for (int r = 0; r < 8; r++) begin
            w_pb = w_pb & ~(w_eff[r*8 +: 8] & {8{~PA_I[r]}});
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            PB_O  <= 8'hFF;
            PC0_O <= 1'b1;
        end else begin
            PB_O  <= w_pb;
            PC0_O <= ~w_stable[64];
        end
    end

    assign KEYS_DB_O = w_stable[63:0];

endmodule
`default_nettype wire

// File: tb/tb_scv_keypad.sv
`default_nettype none
// ============================================================================
// Module      : tb_scv_keypad
// Description : Directed self-checking bench for scv_keypad (DB_DIV=4,
//               DB_CNT=3, AF_DIV=2); autofire vectors need SCV_KEYPAD_AUTOFIRE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scv_keypad;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [63:0] KEYS_I;
    logic        PAUSE_I;
    logic [7:0]  PA_I;
    logic [7:0]  PB_O;
    logic        PC0_O;
    logic [63:0] KEYS_DB_O;
`ifdef SCV_KEYPAD_AUTOFIRE_EN
    logic [63:0] AF_MASK_I;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int cyc;

    scv_keypad #(
        .DB_DIV (4),
        .DB_CNT (3),
        .AF_DIV (2)
    ) u_dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .KEYS_I    (KEYS_I),
        .PAUSE_I   (PAUSE_I),
`ifdef SCV_KEYPAD_AUTOFIRE_EN
        .AF_MASK_I (AF_MASK_I),
`endif
        .PA_I      (PA_I),
        .PB_O      (PB_O),
        .PC0_O     (PC0_O),
        .KEYS_DB_O (KEYS_DB_O)
    );

    always #5 CLK = ~CLK;

    // Edges since reset release; a debounce tick lands on every edge that
    // leaves cyc a multiple of 4.
    always @(posedge CLK or posedge RESET) begin
        if (RESET) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cyc %0d)", tag, act, exp, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic align_tick();
        for (int i = 0; i < 4 && (cyc % 4) != 0; i++) step(1);
    endtask

    initial begin
        RESET   = 1'b1;
        KEYS_I  = '1;
        PAUSE_I = 1'b1;
        PA_I    = 8'h00;
`ifdef SCV_KEYPAD_AUTOFIRE_EN
        AF_MASK_I = '0;
`endif
        #1;
        check("rst_pb", PB_O, 64'hFF);
        check("rst_pc0", PC0_O, 64'h1);
        check("rst_db", KEYS_DB_O, 64'h0);
        step(20);
        check("rst_pb_hold", PB_O, 64'hFF);
        check("rst_pc0_hold", PC0_O, 64'h1);
        check("rst_db_hold", KEYS_DB_O, 64'h0);

        KEYS_I  = '0;
        PAUSE_I = 1'b0;
        PA_I    = 8'hF7;
        step(1);
        RESET = 1'b0;
        step(8);
        check("idle_pb", PB_O, 64'hFF);

        // Press (3,5): stable on the 3rd tick edge (+12), PB one edge later.
        align_tick();
        KEYS_I[29] = 1'b1;
        step(11);
        check("press_db_early", KEYS_DB_O, 64'h0);
        step(1);
        check("press_db", KEYS_DB_O, 64'h0000_0000_2000_0000);
        check("press_pb_lat", PB_O, 64'hFF);
        step(1);
        check("press_pb", PB_O, 64'hDF);
        PA_I = 8'hFE;
        step(1);
        check("other_row_pb", PB_O, 64'hFF);
        PA_I = 8'hF7;
        step(1);
        check("back_row_pb", PB_O, 64'hDF);

        align_tick();
        KEYS_I[29] = 1'b0;
        step(11);
        check("rel_db_early", KEYS_DB_O, 64'h0000_0000_2000_0000);
        step(1);
        check("rel_db", KEYS_DB_O, 64'h0);
        step(1);
        check("rel_pb", PB_O, 64'hFF);

        // Bounce: high 2 ticks, low 1, high 2 -> never accepted.
        align_tick();
        KEYS_I[0] = 1'b1;
        step(8);
        KEYS_I[0] = 1'b0;
        step(4);
        check("bounce_db_mid", KEYS_DB_O, 64'h0);
        KEYS_I[0] = 1'b1;
        step(8);
        KEYS_I[0] = 1'b0;
        check("bounce_db_hi", KEYS_DB_O, 64'h0);
        step(16);
        check("bounce_db_end", KEYS_DB_O, 64'h0);

        // Multi-row wired-AND.
        KEYS_I[1]  = 1'b1;
        KEYS_I[62] = 1'b1;
        step(24);
        check("multi_db", KEYS_DB_O, 64'h4000_0000_0000_0002);
        PA_I = 8'h7E;
        step(1);
        check("multi_7e", PB_O, 64'hBD);
        PA_I = 8'h7F;
        step(1);
        check("multi_7f", PB_O, 64'hBF);
        PA_I = 8'hFE;
        step(1);
        check("multi_fe", PB_O, 64'hFD);
        PA_I = 8'hFF;
        step(1);
        check("multi_ff", PB_O, 64'hFF);

        // Pause, then asynchronous reset mid-operation.
        PA_I = 8'h7E;
        align_tick();
        PAUSE_I = 1'b1;
        step(12);
        check("pause_early", PC0_O, 64'h1);
        step(1);
        check("pause_on", PC0_O, 64'h0);
        check("pause_pb", PB_O, 64'hBD);
        RESET = 1'b1;
        #1;
        check("midrst_pc0", PC0_O, 64'h1);
        check("midrst_pb", PB_O, 64'hFF);
        check("midrst_db", KEYS_DB_O, 64'h0);
        step(3);
        RESET = 1'b0;
        step(12);
        check("repause_early", PC0_O, 64'h1);
        step(1);
        check("repause_on", PC0_O, 64'h0);
        check("repause_db", KEYS_DB_O, 64'h4000_0000_0000_0002);

`ifdef SCV_KEYPAD_AUTOFIRE_EN
        // Phase is 1 for cyc in [16j,16j+8); PB reflects the previous edge.
        KEYS_I    = '0;
        KEYS_I[8] = 1'b1;
        AF_MASK_I = '0;
        AF_MASK_I[8] = 1'b1;
        PA_I = 8'hFD;
        step(24);
        for (int k = 0; k < 32; k++) begin
            check("af_pb0", {63'h0, PB_O[0]}, {63'h0, ((((cyc - 1) / 8) % 2) != 0)});
            step(1);
        end
        AF_MASK_I = '0;
        step(1);
        for (int k = 0; k < 16; k++) begin
            check("af_off_pb0", {63'h0, PB_O[0]}, 64'h0);
            step(1);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
